// File: rtl/zvc_line_scheduler_pkg.sv
// Shared widths, FSM encoding and tag layout for the ZVC line scheduler.
package zvc_line_scheduler_pkg;

   localparam int WORD_WIDTH    = 8;
   localparam int DIST_WIDTH    = 7;
   localparam int MAX_LIFM_RSIZ = 4;
   localparam int PIPE_LAT      = 2;
   localparam int OBUF_DEPTH    = 4;
   localparam int LCNT_WIDTH    = 16;
   localparam int NUM_ENT       = 128;

   localparam int ENT_W  = DIST_WIDTH * MAX_LIFM_RSIZ;
   localparam int LINE_W = NUM_ENT * WORD_WIDTH;
   localparam int MT_W   = NUM_ENT * ENT_W;
   localparam int NNZ_W  = 8;
   localparam int OBUF_W = LINE_W + MT_W + NNZ_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [NNZ_W-1:0] nnz;
      logic             last;
   } tag_t;

   // Number of mapping-table entries whose distance field is nonzero.
   function automatic logic [NNZ_W-1:0] mt_nnz(input logic [MT_W-1:0] mt);
      logic [NNZ_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (mt[i*ENT_W +: ENT_W] != '0) n = n + NNZ_W'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/zvc_obuf_fifo.sv
// Output buffer for compressed lines: synchronous FIFO with occupancy count.
module zvc_obuf_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   // Storage is not reset, so the head is forced to zero while empty.
   assign head_data = empty ? '0 : mem[rd_ptr];

   // Entry storage, written on push.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Credit flow control upstream makes overflow and underflow impossible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && full && !pop));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/zvc_line_scheduler.sv
// Issues lowered-IFM / mapping-table lines into the ZVC pipeline and buffers
// the compressed results for downstream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; cfg sampled on start
// ST_RUN   | accepting and issuing lines until cfg lines issued
// ST_DRAIN | all lines issued; waiting for the last one to be popped
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module zvc_line_scheduler
   import zvc_line_scheduler_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LCNT_WIDTH-1:0] cfg_num_lines,
   output logic                  busy,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LINE_W-1:0]     in_lifm,
   input  logic [MT_W-1:0]       in_mt,
   output logic [LINE_W-1:0]     zvc_lifm_line,
   output logic [MT_W-1:0]       zvc_mt_line,
   input  logic [LINE_W-1:0]     zvc_lifm_comp,
   input  logic [MT_W-1:0]       zvc_mt_comp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LINE_W-1:0]     out_lifm,
   output logic [MT_W-1:0]       out_mt,
   output logic [NNZ_W-1:0]      out_nnz,
   output logic                  out_last
);

   localparam int OCNT_W = $clog2(OBUF_DEPTH + 1);
   localparam int ACC_W  = $clog2(OBUF_DEPTH + PIPE_LAT + 1);

   state_t                state;
   logic [LCNT_WIDTH-1:0] cfg_q;
   logic [LCNT_WIDTH-1:0] issued;
   logic [LCNT_WIDTH-1:0] popped;
   // The issuing cycle is the combinational first tag stage; these are the
   // registered stages that follow the compressor's internal registers.
   tag_t                  tag_q [PIPE_LAT];
   logic [OCNT_W-1:0]     obuf_count;
   logic                  obuf_empty;
   logic [OBUF_W-1:0]     obuf_head;
   logic [ACC_W-1:0]      inflight;
   logic [ACC_W-1:0]      occupied;
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Lines issued but not yet landed in the output buffer.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + ACC_W'(tag_q[i].vld);
   end

   // Credits depend only on registered state, so out_ready never reaches in_ready.
   assign occupied      = inflight + ACC_W'(obuf_count);
   assign in_ready      = (state == ST_RUN) && (issued < cfg_q) && (occupied < ACC_W'(OBUF_DEPTH));
   assign issue         = in_valid && in_ready;
   assign zvc_lifm_line = issue ? in_lifm : '0;
   assign zvc_mt_line   = issue ? in_mt : '0;
   assign push          = tag_q[PIPE_LAT-1].vld;
   assign pop           = out_valid && out_ready;
   assign out_valid     = !obuf_empty;
   assign busy          = (state == ST_RUN) || (state == ST_DRAIN);
   assign done          = (state == ST_DONE);
   assign {out_lifm, out_mt, out_nnz, out_last} = obuf_head;

   // Tag pipeline tracking which compressor slots carry real lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0].vld  <= issue;
         tag_q[0].nnz  <= issue ? mt_nnz(in_mt) : '0;
         tag_q[0].last <= issue && (issued == cfg_q - LCNT_WIDTH'(1));
         for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   zvc_obuf_fifo #(
      .WIDTH (OBUF_W),
      .DEPTH (OBUF_DEPTH),
      .CNT_W (OCNT_W)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({zvc_lifm_comp, zvc_mt_comp, tag_q[PIPE_LAT-1].nnz, tag_q[PIPE_LAT-1].last}),
      .pop       (pop),
      .head_data (obuf_head),
      .count     (obuf_count),
      .empty     (obuf_empty)
   );

   // Tile sequencing and saturating line counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cfg_q  <= '0;
         issued <= '0;
         popped <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cfg_q  <= cfg_num_lines;
                  issued <= '0;
                  popped <= '0;
                  state  <= (cfg_num_lines == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) issued <= issued + LCNT_WIDTH'(1);
               if (pop && popped != cfg_q) popped <= popped + LCNT_WIDTH'(1);
               if (issued == cfg_q) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && popped != cfg_q) popped <= popped + LCNT_WIDTH'(1);
               // Leaving on the popping cycle puts done right after the last pop.
               if (popped == cfg_q || (pop && popped == cfg_q - LCNT_WIDTH'(1)))
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zvc_line_scheduler.sv
// Directed bench for zvc_line_scheduler with a transaction-level reference model.
module tb_zvc_line_scheduler;

   localparam int NE = 128;
   localparam int EW = 28;
   localparam int LW = NE * 8;
   localparam int MW = NE * EW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   cfg_num_lines;
   logic          busy, done;
   logic          in_valid, in_ready;
   logic [LW-1:0] in_lifm;
   logic [MW-1:0] in_mt;
   logic [LW-1:0] zvc_lifm_line, zvc_lifm_comp;
   logic [MW-1:0] zvc_mt_line, zvc_mt_comp;
   logic          out_valid, out_ready;
   logic [LW-1:0] out_lifm;
   logic [MW-1:0] out_mt;
   logic [7:0]    out_nnz;
   logic          out_last;

   always #5 clk = ~clk;

   zvc_line_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .cfg_num_lines(cfg_num_lines),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
      .in_lifm(in_lifm), .in_mt(in_mt), .zvc_lifm_line(zvc_lifm_line),
      .zvc_mt_line(zvc_mt_line), .zvc_lifm_comp(zvc_lifm_comp), .zvc_mt_comp(zvc_mt_comp),
      .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm),
      .out_mt(out_mt), .out_nnz(out_nnz), .out_last(out_last)
   );

   // ---------------- compressor stand-in: keep entries with nonzero mt, pack low
   function automatic logic [LW-1:0] comp_lifm(input logic [LW-1:0] l, input logic [MW-1:0] m);
      logic [LW-1:0] r;
      int k;
      r = '0; k = 0;
      for (int i = 0; i < NE; i++)
         if (m[i*EW +: EW] != '0) begin r[k*8 +: 8] = l[i*8 +: 8]; k++; end
      return r;
   endfunction

   function automatic logic [MW-1:0] comp_mt(input logic [MW-1:0] m);
      logic [MW-1:0] r;
      int k;
      r = '0; k = 0;
      for (int i = 0; i < NE; i++)
         if (m[i*EW +: EW] != '0) begin r[k*EW +: EW] = m[i*EW +: EW]; k++; end
      return r;
   endfunction

   function automatic int count_nz(input logic [MW-1:0] m);
      int n = 0;
      for (int i = 0; i < NE; i++) if (m[i*EW +: EW] != '0) n++;
      return n;
   endfunction

   logic [LW-1:0] c1_l, c2_l;
   logic [MW-1:0] c1_m, c2_m;
   always @(posedge clk) begin
      c1_l <= comp_lifm(zvc_lifm_line, zvc_mt_line);
      c1_m <= comp_mt(zvc_mt_line);
      c2_l <= c1_l;
      c2_m <= c1_m;
   end
   assign zvc_lifm_comp = c2_l;
   assign zvc_mt_comp   = c2_m;

   // ---------------- stimulus lines
   logic [LW-1:0] lifm_arr [16];
   logic [MW-1:0] mt_arr [16];

   function automatic logic [LW-1:0] gen_lifm(input int s);
      logic [LW-1:0] r;
      for (int i = 0; i < NE; i++) r[i*8 +: 8] = 8'(s * 37 + i * 5 + 1);
      return r;
   endfunction

   // kind 0: scattered nonzero entries; 1: entries 0..63 nonzero; 2: all zero
   function automatic logic [MW-1:0] gen_mt(input int s, input int kind);
      logic [MW-1:0] r;
      r = '0;
      for (int i = 0; i < NE; i++) begin
         if (kind == 0 && ((i + s) % 3) != 0) r[i*EW +: EW] = EW'(i * 3 + s + 1);
         if (kind == 1 && i < 64)             r[i*EW +: EW] = EW'(i + 1);
      end
      return r;
   endfunction

   // ---------------- checking
   int n_checks = 0;
   int n_pass   = 0;
   int ncyc     = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
   endtask

   task automatic chk_w(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: low bits got %0h expected %0h (cycle %0d)", name, act[63:0], exp[63:0], ncyc);
   endtask

   // ---------------- reference model: lines issued-not-popped, order, latency
   typedef struct {
      int            rdy;
      logic [LW-1:0] l;
      logic [MW-1:0] m;
      int            nnz;
      bit            last;
   } exp_t;

   exp_t mq[$];
   int   m_cfg = 0, m_iss = 0, m_pop = 0, m_done_at = -1;
   bit   m_active = 1'b0;

   // event records of the current tile
   int            first_iss, first_pop, last_pop, n_pops, n_iss, last_idx, done_cyc;
   bit            busy_seen;
   int            pop_nnz [16];
   logic [LW-1:0] pop_l0;

   task automatic clear_rec();
      first_iss = -1; first_pop = -1; last_pop = -1; n_pops = 0; n_iss = 0;
      last_idx = -1; done_cyc = -1; busy_seen = 1'b0; pop_l0 = '0;
      for (int i = 0; i < 16; i++) pop_nnz[i] = -1;
   endtask

   always @(negedge clk) begin
      bit   e_rdy, e_ov, fire_in, idle;
      exp_t e;
      if (chk_en) begin
         idle  = !m_active && (ncyc != m_done_at);
         e_rdy = m_active && (m_iss < m_cfg) && ((m_iss - m_pop) < 4);
         e_ov  = (mq.size() > 0) && (mq[0].rdy <= ncyc);
         chk("in_ready", 64'(in_ready), 64'(e_rdy));
         chk("out_valid", 64'(out_valid), 64'(e_ov));
         chk("busy", 64'(busy), 64'(m_active));
         chk("done", 64'(done), 64'(ncyc == m_done_at));
         fire_in = in_valid && e_rdy;
         chk_w("zvc_lifm_line", MW'(zvc_lifm_line), fire_in ? MW'(in_lifm) : '0);
         chk_w("zvc_mt_line", zvc_mt_line, fire_in ? in_mt : '0);
         if (e_ov) begin
            chk_w("out_lifm", MW'(out_lifm), MW'(mq[0].l));
            chk_w("out_mt", out_mt, mq[0].m);
            chk("out_nnz", 64'(out_nnz), 64'(mq[0].nnz));
            chk("out_last", 64'(out_last), 64'(mq[0].last));
         end
         if (in_valid && in_ready) begin
            if (first_iss < 0) first_iss = ncyc;
            n_iss++;
         end
         if (out_valid && out_ready) begin
            if (first_pop < 0) first_pop = ncyc;
            last_pop = ncyc;
            if (n_pops < 16) pop_nnz[n_pops] = int'(out_nnz);
            if (n_pops == 0) pop_l0 = out_lifm;
            if (out_last) last_idx = n_pops;
            n_pops++;
         end
         if (done) done_cyc = ncyc;
         if (busy) busy_seen = 1'b1;
         if (reset) begin
            mq.delete();
            m_active = 1'b0; m_done_at = -1; m_iss = 0; m_pop = 0;
         end else begin
            if (fire_in) begin
               e.rdy  = ncyc + 3;
               e.l    = comp_lifm(in_lifm, in_mt);
               e.m    = comp_mt(in_mt);
               e.nnz  = count_nz(in_mt);
               e.last = (m_iss == m_cfg - 1);
               mq.push_back(e);
               m_iss++;
            end
            if (e_ov && out_ready) begin
               if (mq[0].last) begin m_active = 1'b0; m_done_at = ncyc + 1; end
               void'(mq.pop_front());
               m_pop++;
            end
            if (start && idle) begin
               if (cfg_num_lines == 16'd0) m_done_at = ncyc + 1;
               else begin
                  m_active = 1'b1; m_cfg = int'(cfg_num_lines); m_iss = 0; m_pop = 0;
               end
            end
         end
      end
      ncyc++;
   end

   // ---------------- driver
   int feed_idx = 0, feed_n = 0, start_cyc = 0;
   bit feed_en = 1'b0;

   task automatic update_inputs();
      in_valid = feed_en && (feed_idx < feed_n);
      if (in_valid) begin in_lifm = lifm_arr[feed_idx]; in_mt = mt_arr[feed_idx]; end
      else begin in_lifm = '0; in_mt = '0; end
   endtask

   task automatic step();
      bit fire;
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) feed_idx++;
      start = 1'b0;
      update_inputs();
   endtask

   task automatic load_lines(input int base, input int n, input int kind);
      for (int j = 0; j < n; j++) begin
         lifm_arr[j] = gen_lifm(base + j);
         mt_arr[j]   = gen_mt(base + j, kind);
      end
   endtask

   task automatic begin_tile(input int cfg, input int nlines);
      clear_rec();
      cfg_num_lines = 16'(cfg);
      start     = 1'b1;
      feed_idx  = 0;
      feed_n    = nlines;
      feed_en   = 1'b1;
      start_cyc = ncyc;
      update_inputs();
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cyc < 0 && n < budget) begin step(); n++; end
      chk(name, 64'(done_cyc >= 0), 64'd1);
      repeat (2) step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; cfg_num_lines = '0; out_ready = 1'b1;
      in_valid = 1'b0; in_lifm = '0; in_mt = '0;
      clear_rec();
      @(posedge clk); #1;
      chk_en = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out_nnz", 64'(out_nnz), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk_w("rst_out_lifm", MW'(out_lifm), '0);
      chk_w("rst_zvc_mt_line", zvc_mt_line, '0);
      step();
      reset = 1'b0;
      step();

      // A: full-rate tile of 8
      load_lines(10, 8, 0);
      begin_tile(8, 8);
      wait_done(60, "A_done_seen");
      chk("A_first_issue", 64'(first_iss), 64'(start_cyc + 1));
      chk("A_latency", 64'(first_pop - first_iss), 64'd3);
      chk("A_span", 64'(last_pop - first_pop), 64'd7);
      chk("A_npops", 64'(n_pops), 64'd8);
      chk("A_last_idx", 64'(last_idx), 64'd7);
      chk("A_done_cyc", 64'(done_cyc), 64'(start_cyc + 12));

      // B: half-dense line then all-zero mt line
      lifm_arr[0] = gen_lifm(20); mt_arr[0] = gen_mt(20, 1);
      lifm_arr[1] = gen_lifm(21); mt_arr[1] = gen_mt(21, 2);
      begin_tile(2, 2);
      wait_done(40, "B_done_seen");
      chk("B_nnz_half", 64'(pop_nnz[0]), 64'd64);
      chk("B_nnz_zero", 64'(pop_nnz[1]), 64'd0);
      chk_w("B_lifm_packed", MW'(pop_l0), MW'({512'b0, lifm_arr[0][511:0]}));

      // C: backpressure limits issue to buffer depth
      load_lines(30, 10, 0);
      out_ready = 1'b0;
      begin_tile(10, 10);
      repeat (20) step();
      chk("C_issued_stalled", 64'(n_iss), 64'd4);
      chk("C_in_ready_low", 64'(in_ready), 64'd0);
      chk("C_no_pops", 64'(n_pops), 64'd0);
      out_ready = 1'b1;
      wait_done(80, "C_done_seen");
      chk("C_npops", 64'(n_pops), 64'd10);
      chk("C_last_idx", 64'(last_idx), 64'd9);

      // D: empty tile
      begin_tile(0, 0);
      wait_done(10, "D_done_seen");
      chk("D_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
      chk("D_busy_seen", 64'(busy_seen), 64'd0);
      chk("D_npops", 64'(n_pops), 64'd0);

      // E: reset with three lines in flight, then a fresh tile
      load_lines(40, 3, 0);
      out_ready = 1'b0;
      begin_tile(8, 3);
      n = 0;
      while (n_iss < 3 && n < 20) begin step(); n++; end
      chk("E_three_issued", 64'(n_iss), 64'd3);
      chk("E_out_valid_before", 64'(out_valid), 64'd1);
      reset = 1'b1;
      step();
      chk("E_out_valid_after", 64'(out_valid), 64'd0);
      chk("E_busy_after", 64'(busy), 64'd0);
      reset = 1'b0; feed_en = 1'b0; out_ready = 1'b1;
      update_inputs();
      repeat (4) step();
      load_lines(50, 2, 0);
      begin_tile(2, 2);
      wait_done(40, "E_done_seen");
      chk("E_npops", 64'(n_pops), 64'd2);
      chk("E_last_idx", 64'(last_idx), 64'd1);

      // F: start pulse during RUN is ignored
      load_lines(60, 6, 0);
      begin_tile(6, 6);
      repeat (2) step();
      cfg_num_lines = 16'd3;
      start = 1'b1;
      step();
      wait_done(60, "F_done_seen");
      chk("F_npops", 64'(n_pops), 64'd6);
      chk("F_last_idx", 64'(last_idx), 64'd5);
      chk("F_done_cyc", 64'(done_cyc), 64'(start_cyc + 10));

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
